acc_tdpram: RTL and testbench
=============================

ACC_TDPRAM -- requirements
Module: acc_tdpram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width; stored values are signed two's complement.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter SATURATE, default 1; 1 = saturating accumulate, 0 = wrap-around accumulate.
REQ-004 SHALL have parameter INIT_CLEAR, default 1; 1 = clear sequence starts automatically after reset release.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-006 SHALL have the port list below, in this order:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  one-cycle request to zero the whole memory.
- busy  out  1  clear sequence in progress.
- a_en  in  1  port A issues an operation this cycle.
- a_op  in  2  00 read, 01 write, 10 accumulate, 11 read-and-clear.
- a_addr  in  ADDR_WIDTH  port A address.
- a_din  in  DATA_WIDTH  write data or addend.
- a_dout  out  DATA_WIDTH  pre-operation word at a_addr.
- a_valid  out  1  a_dout valid.
- b_en, b_op, b_addr, b_din, b_dout, b_valid  same widths and meanings for port B.

Function
REQ-007 SHALL implement every op as read-first: x_dout returns the word's value before this op, registered; x_valid asserts exactly 1 cycle after the issuing cycle, for one cycle per op.
REQ-008 SHALL keep x_dout at its last value while x_valid = 0.
REQ-009 Write SHALL commit x_din; read-and-clear SHALL commit 0; read SHALL commit nothing.
REQ-010 Accumulate SHALL compute old + x_din and commit the result at the end of the cycle after issue (2-stage RMW).
REQ-011 SATURATE=1: the result SHALL clamp to +2**(DATA_WIDTH-1)-1 / -2**(DATA_WIDTH-1) on overflow. SATURATE=0: the result SHALL keep the low DATA_WIDTH bits.
REQ-012 SHALL allow a new op on each port every cycle (throughput 1/cycle/port), including back-to-back accumulates to the same address.
REQ-013 Hazard: if an op's address matches the address of a pending RMW writeback on either port, the op SHALL see the forwarded writeback value, never the stale RAM word.
REQ-014 Same-address collision, both ports accumulate: the committed value SHALL be sat(old + a_din + b_din) with a single clamp on the full sum; both douts return old.
REQ-015 Same-address collision with a write or read-and-clear on either port: the write-class op SHALL win (port A wins if both are write-class); a colliding accumulate SHALL be discarded.
REQ-016 Same-address read vs any op: the read SHALL return old; the other op SHALL commit normally.
REQ-017 Clear FSM states: IDLE, CLEAR. IDLE->CLEAR on clr=1 (or on the first cycle after reset release when INIT_CLEAR=1). In CLEAR, SHALL write 0 to addresses 0..2**ADDR_WIDTH-1, one per cycle in ascending order, then return to IDLE. busy = 1 exactly while in CLEAR.
REQ-018 While busy = 1: x_en SHALL be ignored (no write, no x_valid) and clr SHALL be ignored; an RMW in flight at clr SHALL commit before clearing begins at address 0.
REQ-019 Address counter SHALL be ADDR_WIDTH+1 bits, with no wrap into a second pass.

Reset
REQ-020 While rst_n = 0: busy = 0, a_valid = b_valid = 0, a_dout = b_dout = 0, pending RMW state discarded, FSM = IDLE; memory contents are undefined/unchanged.
REQ-021 rst_n asserted mid-clear SHALL abort the clear; after release, INIT_CLEAR=1 SHALL restart the clear from address 0.

Verification
REQ-022 Reset release with INIT_CLEAR=1, depth 1024 -> busy high for exactly 1024 cycles; a subsequent read of any address returns 0.
REQ-023 A: write addr 5 = 100; then accumulate addr 5 with din 7 for 3 consecutive cycles -> a_dout = 100, 107, 114; a final read returns 121.
REQ-024 Same cycle: A accumulates addr 9 by 3, B accumulates addr 9 by 4, old = 10 -> both douts = 10; the next read returns 17.
REQ-025 SATURATE=1, word = 32760, accumulate +100 -> commits 32767; word = -32760, accumulate -100 -> commits -32768. SATURATE=0: 32760 + 100 -> -32676.
REQ-026 Same cycle to addr 3 (old 50): A write 1, B accumulate 5 -> memory = 1; read-and-clear on addr 3 returns 1 and the next read returns 0.
REQ-027 Pulse rst_n low at clear address 400 -> busy, valid and dout are 0 immediately; after release the clear restarts at 0 and completes in 1024 cycles.

Source files
------------

// File: rtl/acc_tdpram.sv
// Dual-port word memory with read/write/accumulate/read-and-clear per port.
// Every op is read-first; accumulates retire one cycle after issue and are forwarded to younger ops.
module acc_tdpram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int SATURATE   = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  a_en,
  input  logic [1:0]            a_op,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,
  input  logic                  b_en,
  input  logic [1:0]            b_op,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic signed [DATA_WIDTH+1:0] SUM_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH+1:0] SUM_MIN = ~SUM_MAX;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                  r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]     r_cnt, w_cnt_nxt;
  logic                    r_init_pend;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    r_a_pv, r_b_pv;
  logic [ADDR_WIDTH-1:0]   r_a_pa, r_b_pa;
  logic [DATA_WIDTH-1:0]   r_a_pold, r_b_pold;
  logic [DATA_WIDTH:0]     r_a_padd, r_b_padd;
  logic [DATA_WIDTH-1:0]   r_a_dout, r_b_dout;
  logic                    r_a_valid, r_b_valid;

  logic                    w_idle, w_a_go, w_b_go, w_same;
  logic                    w_a_isacc, w_b_isacc;
  logic                    w_a_wr, w_b_wr, w_a_acc, w_b_acc;
  logic [DATA_WIDTH:0]     w_a_add, w_b_add;
  logic [DATA_WIDTH-1:0]   w_a_wdata, w_b_wdata;
  logic signed [DATA_WIDTH+1:0] w_a_sum, w_b_sum;
  logic [DATA_WIDTH-1:0]   w_a_wb, w_b_wb;
  logic [DATA_WIDTH-1:0]   w_a_old, w_b_old;

  function automatic logic [DATA_WIDTH-1:0] f_fix(input logic signed [DATA_WIDTH+1:0] s);
    if (SATURATE != 0 && s > SUM_MAX) return SUM_MAX[DATA_WIDTH-1:0];
    if (SATURATE != 0 && s < SUM_MIN) return SUM_MIN[DATA_WIDTH-1:0];
    return s[DATA_WIDTH-1:0];
  endfunction

  // Op bit 0 set means write-class (write or read-and-clear).
  assign w_idle    = (r_state == ST_IDLE);
  assign w_a_go    = a_en & w_idle;
  assign w_b_go    = b_en & w_idle;
  assign w_same    = w_a_go & w_b_go & (a_addr == b_addr);
  assign w_a_isacc = (a_op == 2'b10);
  assign w_b_isacc = (b_op == 2'b10);
  assign w_a_wr    = w_a_go & a_op[0];
  assign w_b_wr    = w_b_go & b_op[0] & ~(w_same & a_op[0]);
  assign w_a_acc   = w_a_go & w_a_isacc & ~(w_same & b_op[0]);
  assign w_b_acc   = w_b_go & w_b_isacc & ~(w_same & (a_op[0] | w_a_isacc));
  assign w_a_wdata = (a_op == 2'b01) ? a_din : '0;
  assign w_b_wdata = (b_op == 2'b01) ? b_din : '0;

  // Two accumulates to one address merge into port A so the full sum is clamped once.
  assign w_a_add = {a_din[DATA_WIDTH-1], a_din}
                 + ((w_same & w_b_isacc) ? {b_din[DATA_WIDTH-1], b_din} : '0);
  assign w_b_add = {b_din[DATA_WIDTH-1], b_din};

  assign w_a_sum = {{2{r_a_pold[DATA_WIDTH-1]}}, r_a_pold} + {r_a_padd[DATA_WIDTH], r_a_padd};
  assign w_b_sum = {{2{r_b_pold[DATA_WIDTH-1]}}, r_b_pold} + {r_b_padd[DATA_WIDTH], r_b_padd};
  assign w_a_wb  = f_fix(w_a_sum);
  assign w_b_wb  = f_fix(w_b_sum);

  assign w_a_old = (r_a_pv && r_a_pa == a_addr) ? w_a_wb :
                   (r_b_pv && r_b_pa == a_addr) ? w_b_wb : r_mem[a_addr];
  assign w_b_old = (r_a_pv && r_a_pa == b_addr) ? w_a_wb :
                   (r_b_pv && r_b_pa == b_addr) ? w_b_wb : r_mem[b_addr];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (clr || r_init_pend) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Later statements win: retiring RMWs, then new writes (A over B), then the clear sweep.
  always_ff @(posedge clk) begin
    if (r_a_pv) r_mem[r_a_pa] <= w_a_wb;
    if (r_b_pv) r_mem[r_b_pa] <= w_b_wb;
    if (w_b_wr) r_mem[b_addr] <= w_b_wdata;
    if (w_a_wr) r_mem[a_addr] <= w_a_wdata;
    if (r_state == ST_CLEAR) r_mem[r_cnt[ADDR_WIDTH-1:0]] <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_init_pend <= (INIT_CLEAR != 0);
      r_a_pv      <= 1'b0;
      r_b_pv      <= 1'b0;
      r_a_pa      <= '0;
      r_b_pa      <= '0;
      r_a_pold    <= '0;
      r_b_pold    <= '0;
      r_a_padd    <= '0;
      r_b_padd    <= '0;
      r_a_dout    <= '0;
      r_b_dout    <= '0;
      r_a_valid   <= 1'b0;
      r_b_valid   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init_pend <= 1'b0;
      r_a_valid   <= w_a_go;
      r_b_valid   <= w_b_go;
      if (w_a_go) r_a_dout <= w_a_old;
      if (w_b_go) r_b_dout <= w_b_old;
      r_a_pv      <= w_a_acc;
      r_b_pv      <= w_b_acc;
      r_a_pa      <= a_addr;
      r_b_pa      <= b_addr;
      r_a_pold    <= w_a_old;
      r_b_pold    <= w_b_old;
      r_a_padd    <= w_a_add;
      r_b_padd    <= w_b_add;
    end
  end

  assign busy    = (r_state == ST_CLEAR);
  assign a_dout  = r_a_dout;
  assign b_dout  = r_b_dout;
  assign a_valid = r_a_valid;
  assign b_valid = r_b_valid;

endmodule

// File: tb/tb_acc_tdpram.sv
// Bench for acc_tdpram: a saturating instance driven on both ports against a
// sequential memory model, plus a wrap-around instance on port A.
module tb_acc_tdpram;

  logic        clk = 1'b0;
  logic        rst_n, clr;
  logic        busy;
  logic        a_en, b_en;
  logic [1:0]  a_op, b_op;
  logic [9:0]  a_addr, b_addr;
  logic [15:0] a_din, b_din, a_dout, b_dout;
  logic        a_valid, b_valid;

  logic        w_busy, w_a_en, w_a_valid, w_b_valid;
  logic [1:0]  w_a_op;
  logic [9:0]  w_a_addr;
  logic [15:0] w_a_din, w_a_dout, w_b_dout;

  int n_checks = 0;
  int n_errors = 0;
  int m  [1024];
  int wm [1024];
  logic [15:0] exp_a_q[$], exp_b_q[$], exp_w_q[$];
  logic [15:0] last_a = '0, last_b = '0, last_w = '0;
  logic [15:0] e_a, e_b, e_w;

  always #5 clk = ~clk;

  acc_tdpram dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
    .a_en(a_en), .a_op(a_op), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_valid(a_valid),
    .b_en(b_en), .b_op(b_op), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout), .b_valid(b_valid)
  );

  acc_tdpram #(.SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .busy(w_busy),
    .a_en(w_a_en), .a_op(w_a_op), .a_addr(w_a_addr), .a_din(w_a_din), .a_dout(w_a_dout), .a_valid(w_a_valid),
    .b_en(1'b0), .b_op(2'b00), .b_addr(10'd0), .b_din(16'd0), .b_dout(w_b_dout), .b_valid(w_b_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int f_sat(input int v, input bit sat);
    logic [15:0] t;
    if (sat) begin
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
    end
    t = v[15:0];
    return int'($signed(t));
  endfunction

  // Drives one issue cycle on both ports of the saturating instance and updates the model.
  task automatic op2(input bit ae, input logic [1:0] aop, input int aaddr, input int adin,
                     input bit be, input logic [1:0] bop, input int baddr, input int bdin);
    int oa, ob, sa, sb, va, vb;
    bit aw, bw, aac, bac;
    a_en = ae; a_op = aop; a_addr = 10'(aaddr); a_din = 16'(adin);
    b_en = be; b_op = bop; b_addr = 10'(baddr); b_din = 16'(bdin);
    sa = int'($signed(a_din));
    sb = int'($signed(b_din));
    oa = m[aaddr];
    ob = m[baddr];
    if (ae) exp_a_q.push_back(16'(oa));
    if (be) exp_b_q.push_back(16'(ob));
    aw  = ae && aop[0];
    bw  = be && bop[0];
    aac = ae && (aop == 2'b10);
    bac = be && (bop == 2'b10);
    va  = (aop == 2'b01) ? sa : 0;
    vb  = (bop == 2'b01) ? sb : 0;
    if (ae && be && aaddr == baddr) begin
      if (aw)              m[aaddr] = va;
      else if (bw)         m[aaddr] = vb;
      else if (aac && bac) m[aaddr] = f_sat(oa + sa + sb, 1'b1);
      else if (aac)        m[aaddr] = f_sat(oa + sa, 1'b1);
      else if (bac)        m[aaddr] = f_sat(oa + sb, 1'b1);
    end else begin
      if (aw)       m[aaddr] = va;
      else if (aac) m[aaddr] = f_sat(oa + sa, 1'b1);
      if (bw)       m[baddr] = vb;
      else if (bac) m[baddr] = f_sat(ob + sb, 1'b1);
    end
    @(posedge clk); #1;
    a_en = 1'b0; b_en = 1'b0;
  endtask

  task automatic opa(input logic [1:0] op, input int addr, input int din);
    op2(1'b1, op, addr, din, 1'b0, 2'b00, 0, 0);
  endtask

  task automatic wop(input logic [1:0] op, input int addr, input int din);
    int o, s;
    w_a_en = 1'b1; w_a_op = op; w_a_addr = 10'(addr); w_a_din = 16'(din);
    s = int'($signed(w_a_din));
    o = wm[addr];
    exp_w_q.push_back(16'(o));
    if (op == 2'b01)      wm[addr] = s;
    else if (op == 2'b11) wm[addr] = 0;
    else if (op == 2'b10) wm[addr] = f_sat(o + s, 1'b0);
    @(posedge clk); #1;
    w_a_en = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) break;
    end
    chk(tag, n, 1024);
  endtask

  task automatic model_zero();
    for (int i = 0; i < 1024; i++) m[i] = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_a = '0; last_b = '0; last_w = '0;
    end else begin
      if (a_valid) begin
        if (exp_a_q.size() == 0) chk("a_unexpected_valid", 32'(a_valid), 32'd0);
        else begin
          e_a = exp_a_q.pop_front();
          chk("a_dout", a_dout, e_a);
          last_a = e_a;
        end
      end else chk("a_dout_hold", a_dout, last_a);
      if (b_valid) begin
        if (exp_b_q.size() == 0) chk("b_unexpected_valid", 32'(b_valid), 32'd0);
        else begin
          e_b = exp_b_q.pop_front();
          chk("b_dout", b_dout, e_b);
          last_b = e_b;
        end
      end else chk("b_dout_hold", b_dout, last_b);
      if (w_a_valid) begin
        if (exp_w_q.size() == 0) chk("w_unexpected_valid", 32'(w_a_valid), 32'd0);
        else begin
          e_w = exp_w_q.pop_front();
          chk("w_dout", w_a_dout, e_w);
          last_w = e_w;
        end
      end
      if (w_b_valid) chk("w_b_unexpected_valid", 32'(w_b_valid), 32'd0);
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; clr = 1'b0;
    a_en = 1'b0; a_op = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_op = '0; b_addr = '0; b_din = '0;
    w_a_en = 1'b0; w_a_op = '0; w_a_addr = '0; w_a_din = '0;
    model_zero();
    for (int i = 0; i < 1024; i++) wm[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_dout", a_dout, 0);
    chk("rst_b_dout", b_dout, 0);
    @(negedge clk) rst_n = 1'b1;
    wait_clear("init_busy_cycles");
    chk("wrap_busy_done", w_busy, 0);

    for (int i = 0; i < 4; i++) op2(1'b1, 2'b00, $urandom_range(0, 1023), 0, 1'b1, 2'b00, $urandom_range(0, 1023), 0);
    opa(2'b00, 1023, 0);

    // Consecutive accumulates to one address.
    opa(2'b01, 5, 100);
    repeat (3) opa(2'b10, 5, 7);
    opa(2'b00, 5, 0);

    // Dual accumulate collision.
    opa(2'b01, 9, 10);
    op2(1'b1, 2'b10, 9, 3, 1'b1, 2'b10, 9, 4);
    opa(2'b00, 9, 0);

    // Saturation, including a single clamp on the merged sum.
    opa(2'b01, 20, 32760); opa(2'b10, 20, 100);  opa(2'b00, 20, 0);
    opa(2'b01, 21, -32760); opa(2'b10, 21, -100); opa(2'b00, 21, 0);
    opa(2'b01, 22, 32000);
    op2(1'b1, 2'b10, 22, 1000, 1'b1, 2'b10, 22, -1000);
    opa(2'b00, 22, 0);

    // Write-class op beats a colliding accumulate.
    opa(2'b01, 3, 50);
    op2(1'b1, 2'b01, 3, 1, 1'b1, 2'b10, 3, 5);
    opa(2'b11, 3, 0);
    opa(2'b00, 3, 0);
    op2(1'b1, 2'b10, 4, 9, 1'b1, 2'b11, 4, 0);
    op2(1'b1, 2'b00, 4, 0, 1'b1, 2'b01, 4, 33);
    opa(2'b00, 4, 0);

    // Cross-port forwarding of a pending accumulate.
    opa(2'b01, 30, 40);
    opa(2'b10, 30, 2);
    op2(1'b1, 2'b10, 30, 1, 1'b1, 2'b00, 30, 0);
    op2(1'b0, 2'b00, 0, 0, 1'b1, 2'b00, 30, 0);

    for (int i = 0; i < 300; i++)
      op2($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 65535),
          $urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 65535));

    // Clear with an accumulate in flight; ops and clr ignored while busy.
    opa(2'b01, 0, 77);
    clr = 1'b1;
    opa(2'b10, 0, 5);
    clr = 1'b0;
    model_zero();
    n = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) break;
      if (i < 20) begin
        a_en = 1'b1; a_op = 2'b00; a_addr = 10'd0;
        b_en = 1'b1; b_op = 2'b01; b_addr = 10'd1; b_din = 16'd5;
        clr = (i == 10);
      end else begin
        a_en = 1'b0; b_en = 1'b0; clr = 1'b0;
      end
    end
    chk("clr_busy_cycles", n, 1024);
    op2(1'b1, 2'b00, 0, 0, 1'b1, 2'b00, 1, 0);

    // Reset in the middle of a clear.
    opa(2'b01, 7, 1234);
    clr = 1'b1;
    opa(2'b00, 7, 0);
    clr = 1'b0;
    n = 0;
    for (int i = 0; i < 1500 && n < 401; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("midclr_reached", n, 401);
    rst_n = 1'b0;
    #1;
    chk("midclr_busy", busy, 0);
    chk("midclr_a_valid", a_valid, 0);
    chk("midclr_a_dout", a_dout, 0);
    chk("midclr_b_dout", b_dout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_clear("restart_busy_cycles");
    model_zero();
    for (int i = 0; i < 1024; i++) wm[i] = 0;
    op2(1'b1, 2'b00, 7, 0, 1'b1, 2'b00, 400, 0);
    opa(2'b00, 1023, 0);

    // Wrap-around instance.
    wop(2'b01, 1, 32760); wop(2'b10, 1, 100);  wop(2'b00, 1, 0);
    wop(2'b01, 2, -32760); wop(2'b10, 2, -100); wop(2'b00, 2, 0);
    wop(2'b10, 2, 5); wop(2'b10, 2, 5); wop(2'b11, 2, 0); wop(2'b00, 2, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("a_queue_drained", exp_a_q.size(), 0);
    chk("b_queue_drained", exp_b_q.size(), 0);
    chk("w_queue_drained", exp_w_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
